// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared types and constants for the RAM read streamer
package ram_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rs_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_read_streamer_if.sv
// rtl/ram_read_streamer_if.sv - command, RAM read port and output stream bundle
interface ram_read_streamer_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              start;
  logic [AWIDTH-1:0] start_addr;
  logic [AWIDTH:0]   start_len;
  logic              busy;
  logic              done;
  logic              renable;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, start_addr, start_len, rdata, out_ready,
    output busy, done, renable, raddr, out_valid, out_data, out_last
  );

  modport slave (
    output start, start_addr, start_len, rdata, out_ready,
    input  busy, done, renable, raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_stream_skid_fifo.sv
// rtl/ram_stream_skid_fifo.sv - two-entry FIFO with registered head output
module ram_stream_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   din_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   dout_o,
  output logic [SKID_CW-1:0] count_o,
  output logic               empty_o
);

  logic [WIDTH-1:0]   head_q;
  logic [WIDTH-1:0]   tail_q;
  logic [SKID_CW-1:0] count_q;

  // head_q is always the oldest entry, so the output never passes through logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) head_q <= din_i;
          else               tail_q <= din_i;
          count_q <= count_q + SKID_CW'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - SKID_CW'(1);
        end
        2'b11: begin
          if (count_q == SKID_CW'(1)) begin
            head_q <= din_i;
          end else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout_o  = head_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ram_read_streamer.sv
// rtl/ram_read_streamer.sv - burst reader from a synchronous RAM into a valid/ready stream
module ram_read_streamer
  import ram_stream_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int DWIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  ram_read_streamer_if.master bus
);

  rs_state_t         state_q;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0]   len_q;
  logic [AWIDTH:0]   issued_q, issued_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              done_q;

  logic [SKID_CW-1:0] fifo_count;
  logic               fifo_empty;
  logic [DWIDTH:0]    fifo_dout;
  logic               pop;
  logic               issue_last;
  logic               renable;
  logic [2:0]         occupancy;

  assign pop        = !fifo_empty && bus.out_ready;
  assign issued_d   = issued_q + (AWIDTH + 1)'(1);
  assign issue_last = (issued_d == len_q);
  assign addr_d     = (addr_q == AWIDTH'(DEPTH - 1)) ? '0 : addr_q + AWIDTH'(1);

  // Words already queued or still coming out of the RAM must leave room for this read.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign renable   = (state_q == RUN) && (issued_q < len_q) && (occupancy < 3'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= renable;
      inflight_last_q <= renable && issue_last;
      done_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.start_len != '0) begin
              addr_q   <= bus.start_addr;
              len_q    <= bus.start_len;
              issued_q <= '0;
              state_q  <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (renable) begin
            addr_q   <= addr_d;
            issued_q <= issued_d;
            if (issue_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_dout[DWIDTH]) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_stream_skid_fifo #(.WIDTH(DWIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, bus.rdata}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.renable   = renable;
  assign bus.raddr     = addr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout[DWIDTH-1:0];
  // A stale tag can sit in the head register once the FIFO drains.
  assign bus.out_last  = fifo_dout[DWIDTH] && !fifo_empty;

endmodule

// File: tb/tb_ram_read_streamer.sv
// tb/tb_ram_read_streamer.sv - directed bench for ram_read_streamer against a preloaded RAM model
module tb_ram_read_streamer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_read_streamer_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  ram_read_streamer #(.DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.renable) bus.rdata <= mem[bus.raddr];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  logic [AW-1:0] raddr_log [$];
  int first_valid, done_cyc, last_hs_cyc, ren_cnt, busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (int'(dut.fifo_count) + int'(dut.inflight_q) <= 2) else begin
        errors++;
        $error("FAIL occupancy observed %0d expected <=2", int'(dut.fifo_count) + int'(dut.inflight_q));
      end
    end
  end

  task automatic drive_start(input logic [AW-1:0] a, input logic [AW:0] l);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.start_len  = l;
  endtask

  // mode 0: always ready, 1: stall cycles 6..10 then random, 2: random
  task automatic run_stream(input int mode, input int timeout);
    logic          stall_q;
    logic [DW-1:0] pd;
    logic          pl;
    rx_data.delete(); rx_last.delete(); raddr_log.delete();
    first_valid = -1; done_cyc = -1; last_hs_cyc = -1; ren_cnt = 0; busy_seen = 0;
    stall_q = 1'b0; pd = '0; pl = 1'b0;
    for (int cyc = 1; cyc <= timeout && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc < 6) ? 1'b1 : (cyc <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stall_q) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(pd));
        chk("stall_last", 32'(bus.out_last), 32'(pl));
      end
      if (bus.renable) begin
        ren_cnt++;
        raddr_log.push_back(bus.raddr);
      end
      if (bus.busy) busy_seen = 1;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
        if (bus.out_last) last_hs_cyc = cyc;
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk("done_busy", 32'(bus.busy), 32'd0);
      end
      stall_q = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic check_burst(input string tag, input int a, input int n);
    logic [DW-1:0] e;
    chk($sformatf("%s_count", tag), 32'(rx_data.size()), 32'(n));
    for (int k = 0; k < n && k < rx_data.size(); k++) begin
      e = 8'((a + k) % DEPTH) ^ 8'hA5;
      chk($sformatf("%s_data%0d", tag, k), 32'(rx_data[k]), 32'(e));
      chk($sformatf("%s_last%0d", tag, k), 32'(rx_last[k]), 32'(k == n - 1));
    end
    chk($sformatf("%s_done_lat", tag), 32'(done_cyc), 32'(last_hs_cyc + 1));
  endtask

  initial begin
    logic [DW-1:0] exp1 [8];
    logic [DW-1:0] exp2 [4];
    logic [AW-1:0] adr2 [4];
    exp1 = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};
    exp2 = '{8'hBB, 8'hBA, 8'hA5, 8'hA4};
    adr2 = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i) ^ 8'hA5;

    bus.start = 1'b0; bus.start_addr = '0; bus.start_len = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_renable", 32'(bus.renable), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_raddr", 32'(bus.raddr), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;

    // 1: aligned burst, full throughput
    drive_start(5'd0, 6'd8);
    run_stream(0, 40);
    chk("t1_first_valid", 32'(first_valid), 32'd3);
    chk("t1_last_hs", 32'(last_hs_cyc), 32'd10);
    chk("t1_done_cyc", 32'(done_cyc), 32'd11);
    chk("t1_reads", 32'(ren_cnt), 32'd8);
    for (int k = 0; k < 8 && k < rx_data.size(); k++)
      chk($sformatf("t1_vec%0d", k), 32'(rx_data[k]), 32'(exp1[k]));
    check_burst("t1", 0, 8);

    // 2: address wrap
    drive_start(5'd30, 6'd4);
    run_stream(0, 40);
    for (int k = 0; k < 4 && k < rx_data.size(); k++)
      chk($sformatf("t2_vec%0d", k), 32'(rx_data[k]), 32'(exp2[k]));
    for (int k = 0; k < 4 && k < raddr_log.size(); k++)
      chk($sformatf("t2_raddr%0d", k), 32'(raddr_log[k]), 32'(adr2[k]));
    chk("t2_reads", 32'(ren_cnt), 32'd4);
    check_burst("t2", 30, 4);

    // 3: stall then random backpressure
    drive_start(5'd3, 6'd16);
    run_stream(1, 300);
    chk("t3_reads", 32'(ren_cnt), 32'd16);
    check_burst("t3", 3, 16);

    // 4: zero-length command
    drive_start(5'd9, 6'd0);
    run_stream(0, 6);
    chk("t4_done_cyc", 32'(done_cyc), 32'd1);
    chk("t4_reads", 32'(ren_cnt), 32'd0);
    chk("t4_busy", 32'(busy_seen), 32'd0);
    chk("t4_words", 32'(rx_data.size()), 32'd0);

    // 5: start while busy, then reset mid-burst
    drive_start(5'd10, 6'd6);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.start_addr = 5'd20; bus.start_len = 6'd3;
    #1 chk("t5_valid_c2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); bus.start = 1'b0;
    #1 chk("t5_w0", 32'(bus.out_data), 32'hAF);
    @(negedge clk);
    #1 chk("t5_w1", 32'(bus.out_data), 32'hAE);
    @(negedge clk);
    #1 chk("t5_w2", 32'(bus.out_data), 32'hA9);
    chk("t5_raddr", 32'(bus.raddr), 32'd14);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    chk("t5_rst_renable", 32'(bus.renable), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("t5_no_done", 32'(bus.done), 32'd0);
    end
    drive_start(5'd5, 6'd2);
    run_stream(0, 20);
    if (rx_data.size() == 2) begin
      chk("t5_new0", 32'(rx_data[0]), 32'hA0);
      chk("t5_new1", 32'(rx_data[1]), 32'hA3);
    end
    check_burst("t5", 5, 2);

    // 6: full-depth burst, random ready
    drive_start(5'd7, 6'd32);
    run_stream(2, 600);
    chk("t6_reads", 32'(ren_cnt), 32'd32);
    check_burst("t6", 7, 32);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
